ins_decode_stage: RTL and testbench

//  Buffered, handshaked instruction-decode stage for the Simple RISC Machine datapath.

---
 rtl/ins_pkg.sv | 68 ++++++
 rtl/ins_decode_stage_if.sv | 40 ++++
 rtl/ins_fifo.sv | 50 +++++
 rtl/ins_decode_stage.sv | 103 ++++++++++
 tb/tb_ins_decode_stage.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ins_pkg.sv
// Shared types, encodings and decode helpers for the Simple RISC Machine decode stage.
package ins_pkg;

  localparam logic [2:0] MOV  = 3'b110;
  localparam logic [2:0] ALU  = 3'b101;
  localparam logic [2:0] LDR  = 3'b011;
  localparam logic [2:0] STR  = 3'b100;
  localparam logic [2:0] B    = 3'b001;
  localparam logic [2:0] BL   = 3'b010;
  localparam logic [2:0] HALT = 3'b111;

  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 13;
  localparam int OP_HI   = 12;
  localparam int OP_LO   = 11;
  localparam int RN_HI   = 10;
  localparam int RN_LO   = 8;
  localparam int RD_HI   = 7;
  localparam int RD_LO   = 5;
  localparam int SH_HI   = 4;
  localparam int SH_LO   = 3;
  localparam int RM_HI   = 2;
  localparam int RM_LO   = 0;

  localparam logic [2:0] SEL_RN = 3'b100;
  localparam logic [2:0] SEL_RD = 3'b010;
  localparam logic [2:0] SEL_RM = 3'b001;

  // Immediates are kept raw; sign extension to DATA_W is pure wiring at the top.
  typedef struct packed {
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] cond;
    logic [1:0] shift;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [2:0] rm;
    logic [4:0] imm5;
    logic [7:0] imm8;
    logic       illegal;
  } dec_t;

  function automatic logic is_illegal(input logic [15:0] i);
    logic [2:0] opc;
    logic [1:0] op;
    opc = i[OPC_HI:OPC_LO];
    op  = i[OP_HI:OP_LO];
    return (opc == 3'b000) ||
           ((opc == MOV) && op[0]) ||
           (((opc == LDR) || (opc == STR)) && (op != 2'b00));
  endfunction

  function automatic dec_t decode(input logic [15:0] i);
    dec_t d;
    d.opcode  = i[OPC_HI:OPC_LO];
    d.op      = i[OP_HI:OP_LO];
    d.cond    = i[RN_HI:RN_LO];
    d.shift   = i[SH_HI:SH_LO];
    d.rn      = i[RN_HI:RN_LO];
    d.rd      = i[RD_HI:RD_LO];
    d.rm      = i[RM_HI:RM_LO];
    d.imm5    = i[4:0];
    d.imm8    = i[7:0];
    d.illegal = is_illegal(i);
    return d;
  endfunction

endpackage

// File: rtl/ins_decode_stage_if.sv
// Handshake and decoded-bundle bus between fetch, the decode stage and its consumer.
interface ins_decode_stage_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
);
  logic                       flush;
  logic                       in_valid;
  logic                       in_ready;
  logic [15:0]                in_instr;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic                       out_valid;
  logic                       out_ready;
  logic [2:0]                 opcode;
  logic [1:0]                 op;
  logic [2:0]                 cond;
  logic [1:0]                 shift;
  logic [2:0]                 rn;
  logic [2:0]                 rd;
  logic [2:0]                 rm;
  logic [DATA_W-1:0]          sximm5;
  logic [DATA_W-1:0]          sximm8;
  logic                       illegal;
  logic [2:0]                 rd_sel;
  logic [2:0]                 wr_sel;
  logic [2:0]                 readnum;
  logic [2:0]                 writenum;
  logic                       sel_err;

  modport master (
    output flush, in_valid, in_instr, out_ready, rd_sel, wr_sel,
    input  in_ready, count, out_valid, opcode, op, cond, shift, rn, rd, rm,
           sximm5, sximm8, illegal, readnum, writenum, sel_err
  );

  modport slave (
    input  flush, in_valid, in_instr, out_ready, rd_sel, wr_sel,
    output in_ready, count, out_valid, opcode, op, cond, shift, rn, rd, rm,
           sximm5, sximm8, illegal, readnum, writenum, sel_err
  );
endinterface

// File: rtl/ins_fifo.sv
// Power-of-two instruction queue; storage and occupancy only, no decode.
module ins_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (clear) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop)  rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r <= count_r + CW'(push) - CW'(pop);
    end
  end

  // Storage array, written on accepted pushes.
  always_ff @(posedge clk) begin
    if (push && !clear) mem_r[wr_ptr_r] <= din;
  end

  assign dout  = mem_r[rd_ptr_r];
  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == CW'(0));
  assign count = count_r;
endmodule

// File: rtl/ins_decode_stage.sv
// Queued, handshaked instruction decode stage with read/write register-select muxes.
module ins_decode_stage
  import ins_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  ins_decode_stage_if.slave bus
);
  localparam int CW = $clog2(DEPTH+1);

  logic          ready_en_r;
  logic          out_valid_r;
  dec_t          dec_r;
  logic          in_ready_s;
  logic          push_s;
  logic          pop_s;
  logic          full_s;
  logic          empty_s;
  logic [15:0]   head_s;
  logic [CW-1:0] count_s;
  logic [2:0]    readnum_s;
  logic [2:0]    writenum_s;
  logic          rd_err_s;
  logic          wr_err_s;

  assign in_ready_s = ready_en_r & ~full_s & ~bus.flush;
  assign push_s     = bus.in_valid & in_ready_s;
  assign pop_s      = ~empty_s & (~out_valid_r | bus.out_ready) & ~bus.flush;

  ins_fifo #(.DEPTH(DEPTH), .WIDTH(16)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (bus.flush),
    .push  (push_s),
    .pop   (pop_s),
    .din   (bus.in_instr),
    .dout  (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

  // in_ready stays low until the first edge after reset is released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ready_en_r <= 1'b0;
    else       ready_en_r <= 1'b1;
  end

  // Output register: flush only drops valid, the stale bundle is left in place.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      dec_r       <= '0;
    end else if (bus.flush) begin
      out_valid_r <= 1'b0;
    end else if (pop_s) begin
      out_valid_r <= 1'b1;
      dec_r       <= decode(head_s);
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  // Independent one-hot select muxes over the registered register fields.
  always_comb begin
    readnum_s  = 3'd0;
    writenum_s = 3'd0;
    rd_err_s   = 1'b0;
    wr_err_s   = 1'b0;
    case (bus.rd_sel)
      SEL_RN:  readnum_s = dec_r.rn;
      SEL_RD:  readnum_s = dec_r.rd;
      SEL_RM:  readnum_s = dec_r.rm;
      default: rd_err_s  = 1'b1;
    endcase
    case (bus.wr_sel)
      SEL_RN:  writenum_s = dec_r.rn;
      SEL_RD:  writenum_s = dec_r.rd;
      SEL_RM:  writenum_s = dec_r.rm;
      default: wr_err_s   = 1'b1;
    endcase
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.count     = count_s;
  assign bus.out_valid = out_valid_r;
  assign bus.opcode    = dec_r.opcode;
  assign bus.op        = dec_r.op;
  assign bus.cond      = dec_r.cond;
  assign bus.shift     = dec_r.shift;
  assign bus.rn        = dec_r.rn;
  assign bus.rd        = dec_r.rd;
  assign bus.rm        = dec_r.rm;
  assign bus.sximm5    = {{(DATA_W-5){dec_r.imm5[4]}}, dec_r.imm5};
  assign bus.sximm8    = {{(DATA_W-8){dec_r.imm8[7]}}, dec_r.imm8};
  assign bus.illegal   = dec_r.illegal;
  assign bus.readnum   = readnum_s;
  assign bus.writenum  = writenum_s;
  assign bus.sel_err   = rd_err_s | wr_err_s;
endmodule

// File: tb/tb_ins_decode_stage.sv
// Directed bench for ins_decode_stage: reset, decode, queueing, illegal detection, select muxes, flush.
module tb_ins_decode_stage;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  ins_decode_stage_if #(.DATA_W(16), .DEPTH(4)) bus ();

  ins_decode_stage #(.DATA_W(16), .DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.in_instr = 16'hD101 + 16'(k);
      step();
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bus.count !== 3'd3 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre: count=%0d out_valid=%0b required 3/1", bus.count, bus.out_valid);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: count=%0d out_valid=%0b required 0/0", bus.count, bus.out_valid);
    end
    checks++;
    if (bus.opcode !== 3'd0 || bus.rn !== 3'd0 || bus.sximm8 !== 16'h0000 || bus.illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_fields: opcode=%0h rn=%0h sximm8=%0h illegal=%0b required all 0",
               bus.opcode, bus.rn, bus.sximm8, bus.illegal);
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready: got %0b required 0", bus.in_ready);
    end
    #1 reset = 1'b0;
    step();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_in_ready: got %0b required 1", bus.in_ready);
    end
  endtask

  task automatic test_mov();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 16'hD105;
    step();
    bus.in_valid = 1'b0;
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.opcode !== 3'b110 || bus.op !== 2'b10 || bus.rn !== 3'd1) begin
      errors++;
      $display("FAIL mov_fields: valid=%0b opcode=%0b op=%0b rn=%0d required 1/110/10/1",
               bus.out_valid, bus.opcode, bus.op, bus.rn);
    end
    checks++;
    if (bus.sximm8 !== 16'h0005 || bus.illegal !== 1'b0) begin
      errors++;
      $display("FAIL mov_imm: sximm8=%0h illegal=%0b required 0005/0", bus.sximm8, bus.illegal);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mov_drain: out_valid=%0b required 0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 16'hA0E8;
    step();
    bus.in_instr = 16'hD1FF;
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.rd !== 3'd7 || bus.rm !== 3'd0 || bus.shift !== 2'b01 ||
        bus.opcode !== 3'b101) begin
      errors++;
      $display("FAIL b2b_add: valid=%0b rd=%0d rm=%0d shift=%0b opcode=%0b required 1/7/0/01/101",
               bus.out_valid, bus.rd, bus.rm, bus.shift, bus.opcode);
    end
    checks++;
    if (bus.sximm5 !== 16'h0008) begin
      errors++;
      $display("FAIL b2b_sximm5: got %0h required 0008", bus.sximm5);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.sximm8 !== 16'hFFFF || bus.sximm5 !== 16'hFFFF) begin
      errors++;
      $display("FAIL b2b_sext: valid=%0b sximm8=%0h sximm5=%0h required 1/FFFF/FFFF",
               bus.out_valid, bus.sximm8, bus.sximm5);
    end
    step();
  endtask

  task automatic test_full_wrap();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.in_instr = 16'hD110 + 16'(k);
      step();
    end
    checks++;
    if (bus.count !== 3'd4 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_state: count=%0d in_ready=%0b required 4/0", bus.count, bus.in_ready);
    end
    bus.in_instr = 16'hD1AA;
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.count !== 3'd4 || bus.out_valid !== 1'b1 || bus.sximm8 !== 16'h0010) begin
      errors++;
      $display("FAIL full_stall: count=%0d valid=%0b sximm8=%0h required 4/1/0010",
               bus.count, bus.out_valid, bus.sximm8);
    end
    bus.out_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      step();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.sximm8 !== (16'h0010 + 16'(k))) begin
        errors++;
        $display("FAIL wrap_order[%0d]: valid=%0b sximm8=%0h required 1/%0h",
                 k, bus.out_valid, bus.sximm8, 16'h0010 + 16'(k));
      end
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.count !== 3'd0) begin
      errors++;
      $display("FAIL wrap_drain: valid=%0b count=%0d required 0/0", bus.out_valid, bus.count);
    end
  endtask

  task automatic test_illegal();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 16'h0000;
    step();
    bus.in_instr = 16'h6800;
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.illegal !== 1'b1 || bus.opcode !== 3'b000) begin
      errors++;
      $display("FAIL illegal_0000: valid=%0b illegal=%0b opcode=%0b required 1/1/000",
               bus.out_valid, bus.illegal, bus.opcode);
    end
    bus.in_instr = 16'h6000;
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.illegal !== 1'b1 || bus.op !== 2'b01) begin
      errors++;
      $display("FAIL illegal_6800: valid=%0b illegal=%0b op=%0b required 1/1/01",
               bus.out_valid, bus.illegal, bus.op);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.illegal !== 1'b0 || bus.opcode !== 3'b011) begin
      errors++;
      $display("FAIL legal_6000: valid=%0b illegal=%0b opcode=%0b required 1/0/011",
               bus.out_valid, bus.illegal, bus.opcode);
    end
    step();
  endtask

  task automatic test_select_flush();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 16'hA2A3;
    step();
    bus.in_valid = 1'b0;
    step();
    bus.rd_sel = 3'b001;
    bus.wr_sel = 3'b010;
    #1;
    checks++;
    if (bus.readnum !== 3'd3 || bus.writenum !== 3'd5 || bus.sel_err !== 1'b0) begin
      errors++;
      $display("FAIL sel_valid: readnum=%0d writenum=%0d sel_err=%0b required 3/5/0",
               bus.readnum, bus.writenum, bus.sel_err);
    end
    bus.wr_sel = 3'b100;
    #1;
    checks++;
    if (bus.writenum !== 3'd2 || bus.sel_err !== 1'b0) begin
      errors++;
      $display("FAIL sel_rn: writenum=%0d sel_err=%0b required 2/0", bus.writenum, bus.sel_err);
    end
    bus.rd_sel = 3'b011;
    #1;
    checks++;
    if (bus.readnum !== 3'd0 || bus.sel_err !== 1'b1 || bus.writenum !== 3'd2) begin
      errors++;
      $display("FAIL sel_bad: readnum=%0d sel_err=%0b writenum=%0d required 0/1/2",
               bus.readnum, bus.sel_err, bus.writenum);
    end
    bus.rd_sel   = 3'b100;
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_instr = 16'hD105;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_in_ready: got %0b required 0", bus.in_ready);
    end
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.count !== 3'd0) begin
      errors++;
      $display("FAIL flush_state: valid=%0b count=%0d required 0/0", bus.out_valid, bus.count);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.count !== 3'd0) begin
      errors++;
      $display("FAIL flush_dropped: valid=%0b count=%0d required 0/0", bus.out_valid, bus.count);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = 16'h0000;
    bus.out_ready = 1'b0;
    bus.rd_sel    = 3'b100;
    bus.wr_sel    = 3'b010;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    step();
    test_reset();
    test_mov();
    test_back_to_back();
    test_full_wrap();
    test_illegal();
    test_select_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
